// File: rtl/instr_mem_pkg.sv
// Shared constants, FSM state encoding and instruction word layout for the
// instruction memory responder.
package instr_mem_pkg;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 8;
    localparam int DEPTH   = 256;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_LOAD = 2'd3;

    typedef struct packed {
        logic [OPC_MSB-OPC_LSB:0] opcode;
        logic [IMM_MSB-IMM_LSB:0] imm;
    } instr_t;

    function automatic logic even_parity(input logic [INSTR_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/instr_mem_array.sv
// 256x8 instruction storage: one write port, one registered read port.
// Optional per-word even parity is enabled by defining INSTR_MEM_PARITY_EN.
module instr_mem_array
    import instr_mem_pkg::*;
(
    input  logic               CLK,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_W-1:0]  raddr,
    output instr_t             rd_data,
    output logic               par_err
);

    // Storage is deliberately not reset so a reset never loses a loaded program.
    logic [INSTR_W-1:0] mem [DEPTH];
    instr_t             rd_data_q;
    instr_t             rd_data_d;

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (re) begin
            rd_data_d = mem[raddr];
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

`ifdef INSTR_MEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_err_q;
    logic par_err_d;

    always_ff @(posedge CLK) begin
        if (we) begin
            par_mem[waddr] <= even_parity(wdata);
        end
    end

    // Flag is a one-cycle pulse aligned with the read data register update.
    always_comb begin
        par_err_d = 1'b0;
        if (re) begin
            par_err_d = (even_parity(mem[raddr]) != par_mem[raddr]);
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder with programmable wait states and a byte loader.
// Define INSTR_MEM_PARITY_EN to enable stored-parity checking on fetch.
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
)
(
    input  logic               CLK,
    input  logic               CLB,
    input  logic               fetch_req,
    input  logic [ADDR_W-1:0]  fetch_addr,
    output logic               fetch_ack,
    output logic [INSTR_W-1:0] instr,
    output logic               busy,
    input  logic               ld_en,
    input  logic               ld_valid,
    input  logic [INSTR_W-1:0] ld_data,
    output logic               ld_ready,
    output logic [ADDR_W-1:0]  ld_addr,
    output logic               parity_err
);

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic              ack_q, ack_d;
    logic              mem_we;
    logic              mem_re;
    instr_t            rd_word;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        ld_addr_d = ld_addr_q;
        ack_d     = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A load request takes priority over a simultaneous fetch.
                if (ld_en) begin
                    state_d   = ST_LOAD;
                    ld_addr_d = '0;
                end else if (fetch_req) begin
                    addr_d  = fetch_addr;
                    cnt_d   = '0;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: begin
                mem_re  = 1'b1;
                ack_d   = 1'b1;
                state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    ld_addr_d = ld_addr_q + 8'd1;
                end
                if (!ld_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLB) begin
        if (CLB) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            ld_addr_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            ld_addr_q <= ld_addr_d;
            ack_q     <= ack_d;
        end
    end

    instr_mem_array u_array (
        .CLK     (CLK),
        .rst     (CLB),
        .we      (mem_we),
        .waddr   (ld_addr_q),
        .wdata   (ld_data),
        .re      (mem_re),
        .raddr   (addr_q),
        .rd_data (rd_word),
        .par_err (parity_err)
    );

    assign instr     = rd_word;
    assign fetch_ack = ack_q;
    assign busy      = (state_q == ST_WAIT) || (state_q == ST_RESP);
    assign ld_ready  = (state_q == ST_LOAD);
    assign ld_addr   = ld_addr_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Scoreboard bench: three responders (0, 1 and 3 wait states) share one stimulus
// stream; a transaction-level model predicts acks, data and loader state.
module tb_instr_mem_responder;

    logic       CLK = 1'b0;
    logic       CLB = 1'b0;
    logic       fetch_req = 1'b0;
    logic [7:0] fetch_addr = 8'h00;
    logic       ld_en = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = 8'h00;

    logic       ack_o  [3];
    logic       busy_o [3];
    logic       rdy_o  [3];
    logic       pe_o   [3];
    logic [7:0] instr_o[3];
    logic [7:0] lda_o  [3];

    always #5 CLK = ~CLK;

    instr_mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .CLK(CLK), .CLB(CLB), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(ack_o[0]), .instr(instr_o[0]), .busy(busy_o[0]), .ld_en(ld_en),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy_o[0]), .ld_addr(lda_o[0]),
        .parity_err(pe_o[0]));
    instr_mem_responder #(.WAIT_CYCLES(1)) dut1 (
        .CLK(CLK), .CLB(CLB), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(ack_o[1]), .instr(instr_o[1]), .busy(busy_o[1]), .ld_en(ld_en),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy_o[1]), .ld_addr(lda_o[1]),
        .parity_err(pe_o[1]));
    instr_mem_responder #(.WAIT_CYCLES(3)) dut2 (
        .CLK(CLK), .CLB(CLB), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(ack_o[2]), .instr(instr_o[2]), .busy(busy_o[2]), .ld_en(ld_en),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(rdy_o[2]), .ld_addr(lda_o[2]),
        .parity_err(pe_o[2]));

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
    } exp_t;

    exp_t       sbq [3][$];
    logic [7:0] mmem [3][256];
    bit         bad  [3][256];
    bit         in_load [3];
    int         free_at [3];
    logic [7:0] ldp [3];
    logic [7:0] last_instr [3];
    logic [7:0] lq [$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       mdl_e;
    exp_t       mon_e;

    function automatic int wc(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
    endfunction

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
        end
    endtask

    // Reference model: a fetch accepted at edge c acks at edge c+W+1 and the
    // responder can accept again from edge c+W+2; loads stream into memory.
    always @(posedge CLK) begin
        cyc = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (CLB) begin
                sbq[k].delete();
                in_load[k] = 1'b0;
                free_at[k] = 0;
                ldp[k]     = 8'h00;
            end else if (in_load[k]) begin
                if (ld_valid) begin
                    mmem[k][ldp[k]] = ld_data;
                    bad[k][ldp[k]]  = 1'b0;
                    ldp[k]          = ldp[k] + 8'd1;
                end
                if (!ld_en) in_load[k] = 1'b0;
            end else if (cyc >= free_at[k]) begin
                if (ld_en) begin
                    in_load[k] = 1'b1;
                    ldp[k]     = 8'h00;
                end else if (fetch_req) begin
                    mdl_e.cyc = cyc + wc(k) + 1;
                    mdl_e.d   = mmem[k][fetch_addr];
                    mdl_e.pe  = bad[k][fetch_addr];
                    sbq[k].push_back(mdl_e);
                    free_at[k] = cyc + wc(k) + 2;
                end
            end
        end
    end

    // Monitor: compare every output against the model on the falling edge.
    always @(negedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (CLB) begin
                last_instr[k] = 8'h00;
            end else begin
                chk("busy", k, 32'(busy_o[k]), 32'(cyc < free_at[k] - 1));
                chk("ld_ready", k, 32'(rdy_o[k]), 32'(in_load[k]));
                chk("ld_addr", k, 32'(lda_o[k]), 32'(ldp[k]));
                if (ack_o[k]) begin
                    if (sbq[k].size() == 0) begin
                        chk("unexpected_ack", k, 32'(ack_o[k]), 32'd0);
                    end else begin
                        mon_e = sbq[k].pop_front();
                        chk("ack_cycle", k, 32'(cyc), 32'(mon_e.cyc));
                        chk("instr", k, 32'(instr_o[k]), 32'(mon_e.d));
                        chk("parity_err", k, 32'(pe_o[k]), 32'(mon_e.pe));
                        last_instr[k] = mon_e.d;
                    end
                end else begin
                    chk("instr_hold", k, 32'(instr_o[k]), 32'(last_instr[k]));
                    chk("parity_idle", k, 32'(pe_o[k]), 32'd0);
                    if (sbq[k].size() > 0 && sbq[k][0].cyc <= cyc) begin
                        chk("missing_ack", k, 32'(ack_o[k]), 32'd1);
                        void'(sbq[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs();
        for (int k = 0; k < 3; k++) begin
            chk("rst_ack", k, 32'(ack_o[k]), 32'd0);
            chk("rst_instr", k, 32'(instr_o[k]), 32'd0);
            chk("rst_busy", k, 32'(busy_o[k]), 32'd0);
            chk("rst_ld_ready", k, 32'(rdy_o[k]), 32'd0);
            chk("rst_ld_addr", k, 32'(lda_o[k]), 32'd0);
            chk("rst_parity", k, 32'(pe_o[k]), 32'd0);
        end
    endtask

    task automatic do_load(input int gap_pct);
        @(negedge CLK);
        ld_en = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < lq.size(); ) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                ld_valid = 1'b0;
            end else begin
                ld_valid = 1'b1;
                ld_data  = lq[i];
                i++;
                if (i == lq.size()) ld_en = 1'b0;
            end
            @(negedge CLK);
        end
        ld_valid = 1'b0;
        ld_en    = 1'b0;
        ld_data  = 8'($urandom);
    endtask

    task automatic do_fetch(input logic [7:0] a, input int hold, input bit scramble);
        @(negedge CLK);
        fetch_req  = 1'b1;
        fetch_addr = a;
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            if (scramble) fetch_addr = 8'($urandom);
        end
        fetch_req  = 1'b0;
        fetch_addr = 8'($urandom);
        repeat (7) @(negedge CLK);
    endtask

    task automatic reset_mid_fetch(input logic [7:0] a);
        @(negedge CLK);
        fetch_req  = 1'b1;
        fetch_addr = a;
        @(negedge CLK);
        fetch_req = 1'b0;
        #2 CLB = 1'b1;
        #1 check_reset_outputs();
        @(negedge CLK);
        #1 CLB = 1'b0;
        repeat (6) @(negedge CLK);
    endtask

    task automatic back_to_back();
        int last[3];
        for (int k = 0; k < 3; k++) last[k] = -1;
        @(negedge CLK);
        fetch_req  = 1'b1;
        fetch_addr = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            fetch_addr = 8'($urandom);
            for (int k = 0; k < 3; k++) begin
                if (ack_o[k]) begin
                    if (last[k] >= 0) chk("ack_spacing", k, 32'(cyc - last[k]), 32'(wc(k) + 2));
                    last[k] = cyc;
                end
            end
        end
        fetch_req = 1'b0;
        repeat (7) @(negedge CLK);
    endtask

    task automatic collision();
        @(negedge CLK);
        ld_en      = 1'b1;
        fetch_req  = 1'b1;
        fetch_addr = 8'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            for (int k = 0; k < 3; k++) begin
                chk("coll_ready", k, 32'(rdy_o[k]), 32'd1);
                chk("coll_no_ack", k, 32'(ack_o[k]), 32'd0);
            end
            ld_valid = i[0];
            ld_data  = 8'($urandom);
        end
        ld_en     = 1'b0;
        fetch_req = 1'b0;
        ld_valid  = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 CLB = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(negedge CLK);
        #1 CLB = 1'b0;

        // Load then fetch with a directed timing check on the 1-wait-state unit.
        lq.delete();
        lq.push_back(8'h1A); lq.push_back(8'h2B); lq.push_back(8'h3C);
        do_load(0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk("load3_ld_addr", k, 32'(lda_o[k]), 32'd3);
        @(negedge CLK);
        fetch_req  = 1'b1;
        fetch_addr = 8'h01;
        @(negedge CLK);
        fetch_req  = 1'b0;
        fetch_addr = 8'hC5;
        chk("lat_busy", 1, 32'(busy_o[1]), 32'd1);
        chk("lat_early", 1, 32'(ack_o[1]), 32'd0);
        @(negedge CLK);
        chk("lat_early", 1, 32'(ack_o[1]), 32'd0);
        chk("lat_w0", 0, 32'(ack_o[0]), 32'd1);
        @(negedge CLK);
        chk("lat_ack", 1, 32'(ack_o[1]), 32'd1);
        chk("lat_instr", 1, 32'(instr_o[1]), 32'h2B);
        repeat (5) @(negedge CLK);

        // Reset while fetching, then the loaded program must survive.
        reset_mid_fetch(8'h02);
        do_fetch(8'h00, 1, 1'b0);
        for (int k = 0; k < 3; k++) chk("post_rst_instr", k, 32'(instr_o[k]), 32'h1A);

        // Address wrap: 257 bytes, last one lands at address 0.
        lq.delete();
        for (int i = 0; i < 256; i++) lq.push_back(8'(i));
        lq.push_back(8'hEE);
        do_load(0);
        @(negedge CLK);
        for (int k = 0; k < 3; k++) chk("wrap_ld_addr", k, 32'(lda_o[k]), 32'd1);
        do_fetch(8'h00, 1, 1'b0);
        for (int k = 0; k < 3; k++) chk("wrap_mem0", k, 32'(instr_o[k]), 32'hEE);
        do_fetch(8'hFF, 1, 1'b0);

        collision();
        back_to_back();

`ifdef INSTR_MEM_PARITY_EN
        dut0.u_array.par_mem[2] <= ~dut0.u_array.par_mem[2];
        dut1.u_array.par_mem[2] <= ~dut1.u_array.par_mem[2];
        dut2.u_array.par_mem[2] <= ~dut2.u_array.par_mem[2];
        for (int k = 0; k < 3; k++) bad[k][2] = 1'b1;
        do_fetch(8'h02, 1, 1'b0);
        do_fetch(8'h03, 1, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(3))
                0: do_fetch(8'($urandom), int'($urandom_range(1, 4)), 1'b1);
                1: begin
                    lq.delete();
                    for (int i = 0; i < int'($urandom_range(1, 6)); i++) lq.push_back(8'($urandom));
                    do_load(30);
                    repeat (2) @(negedge CLK);
                end
                2: begin
                    @(negedge CLK);
                    fetch_req  = 1'b1;
                    fetch_addr = 8'($urandom);
                    @(negedge CLK);
                    fetch_req = 1'b0;
                    ld_en     = 1'b1;
                    repeat (8) @(negedge CLK);
                    ld_en = 1'b0;
                    repeat (3) @(negedge CLK);
                end
                default: reset_mid_fetch(8'($urandom));
            endcase
        end

        repeat (10) @(negedge CLK);
        for (int k = 0; k < 3; k++) chk("sb_drain", k, 32'(sbq[k].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
